// File: rtl/csr_pixel_loader_pkg.sv
// Shared state encoding and default geometry for the CSR pixel loader.
package loader_pkg;
    localparam int IMG_W_DEF      = 640;
    localparam int IMG_H_DEF      = 960;
    localparam int PIX_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int PACK           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;
endpackage

// File: rtl/csr_pixel_loader_if.sv
// CPU-side CSR bus of the pixel loader: write strobe/data, start pulse and FIFO status.
interface csr_pixel_loader_if
    import loader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          csr_pixel_we;
    logic [31:0]   csr_pixel_w;
    logic          csr_start;
    logic [LW-1:0] csr_level_r;
    logic          csr_full_r;
    logic          overflow;

    modport master (
        output csr_pixel_we, csr_pixel_w, csr_start,
        input  csr_level_r, csr_full_r, overflow
    );

    modport slave (
        input  csr_pixel_we, csr_pixel_w, csr_start,
        output csr_level_r, csr_full_r, overflow
    );
endinterface

// File: rtl/csr_pixel_loader_input_fifo.sv
// Synchronous pixel FIFO with a registered read port and registered level/full status.
// With LOADER_PACK4_EN defined each push stores PACK pixels and needs PACK free slots.
module input_fifo
    import loader_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int W     = PIX_W_DEF,
    parameter int WPP   = 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WPP*W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     rd_data_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0] level_q, level_d, free_s;
    logic          full_q, full_d;
    logic [W-1:0]  rd_q;
    logic          pop_ok_s, push_ok_s;

    // Push/pop acceptance and next pointer/level state.
    always_comb begin
        free_s   = LW'(DEPTH) - level_q;
        pop_ok_s = pop_i && (level_q != {LW{1'b0}});
`ifdef LOADER_PACK4_EN
        push_ok_s = push_i && (free_s >= LW'(WPP));
`else
        // A pop in the same cycle frees the slot the write will use.
        push_ok_s = push_i && ((free_s != {LW{1'b0}}) || pop_ok_s);
`endif
        wp_d    = push_ok_s ? (wp_q + AW'(WPP)) : wp_q;
        rp_d    = pop_ok_s ? (rp_q + AW'(1)) : rp_q;
        level_d = level_q + (push_ok_s ? LW'(WPP) : {LW{1'b0}})
                          - (pop_ok_s ? LW'(1) : {LW{1'b0}});
        full_d  = (level_d > LW'(DEPTH - WPP));
        drop_o  = push_i && !push_ok_s;
    end

    // Storage array; reading an entry overwritten this cycle returns the old value.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPP; k++) begin
            if (push_ok_s) begin
                mem_q[wp_q + AW'(k)] <= push_data_i[k*W +: W];
            end
        end
    end

    // Pointers, status and the registered read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= {AW{1'b0}};
            rp_q    <= {AW{1'b0}};
            level_q <= {LW{1'b0}};
            full_q  <= 1'b0;
            rd_q    <= {W{1'b0}};
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            full_q  <= full_d;
            if (pop_ok_s) begin
                rd_q <= mem_q[rp_q];
            end
        end
    end

    assign rd_data_o = rd_q;
    assign level_o   = level_q;
    assign full_o    = full_q;
    assign empty_o   = (level_q == {LW{1'b0}});
endmodule

// File: rtl/csr_pixel_loader.sv
// CPU-fed pixel streamer: CSR writes fill a FIFO, csr_start streams one IMG_W x IMG_H frame.
// LOADER_PACK4_EN packs four 8-bit pixels per CSR write (byte 0 first).
module csr_pixel_loader
    import loader_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    csr_pixel_loader_if.slave  csr,
    output logic [PIX_W-1:0]   px_out,
    output logic               valid_out,
    output logic               frame_start,
    output logic               line_end,
    output logic               done,
    output logic [31:0]        pixel_count
);
`ifdef LOADER_PACK4_EN
    localparam int WPP = PACK;
`else
    localparam int WPP = 1;
`endif
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          all_popped_q, all_popped_d;
    logic [31:0]   pix_cnt_q, pix_cnt_d;
    logic          valid_q, fs_q, le_q, done_q, ovf_q;
    logic          fs_d, le_d, ovf_d;
    logic          restart_s, clr_ovf_s, pop_s, push_s, drop_s;
    logic          fifo_empty_s, fifo_drop_s;
    logic [LW-1:0] level_s;
    logic          full_s;
    logic [31:0]   unused_wdata_s;

    assign unused_wdata_s = csr.csr_pixel_w;
    assign push_s = csr.csr_pixel_we && (state_q != ST_DONE);
    assign drop_s = (csr.csr_pixel_we && (state_q == ST_DONE)) || fifo_drop_s;

    input_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W),
        .WPP   (WPP)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (csr.csr_pixel_w[WPP*PIX_W-1:0]),
        .pop_i       (pop_s),
        .rd_data_o   (px_out),
        .level_o     (level_s),
        .full_o      (full_s),
        .empty_o     (fifo_empty_s),
        .drop_o      (fifo_drop_s)
    );

    // Frame FSM, raster counters and next values of the stream markers.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        all_popped_d = all_popped_q;
        pix_cnt_d    = pix_cnt_q;
        restart_s    = 1'b0;
        clr_ovf_s    = 1'b0;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csr.csr_start) begin
                    state_d   = ST_STREAM;
                    restart_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // The last pixel has been popped; leave once it has been emitted.
                if (all_popped_q) begin
                    state_d = ST_DONE;
                end else begin
                    pop_s = !fifo_empty_s;
                end
            end
            ST_DONE: begin
                if (csr.csr_start) begin
                    state_d   = ST_STREAM;
                    restart_s = 1'b1;
                    clr_ovf_s = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (restart_s) begin
            col_d        = {CW{1'b0}};
            row_d        = {RW{1'b0}};
            all_popped_d = 1'b0;
            pix_cnt_d    = 32'd0;
        end else if (pop_s) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = {CW{1'b0}};
                if (row_q == RW'(IMG_H - 1)) begin
                    row_d        = {RW{1'b0}};
                    all_popped_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            pix_cnt_d = pix_cnt_q;
        end

        fs_d  = pop_s && (col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}});
        le_d  = pop_s && (col_q == CW'(IMG_W - 1));
        ovf_d = (clr_ovf_s ? 1'b0 : ovf_q) | drop_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            all_popped_q <= 1'b0;
            pix_cnt_q    <= 32'd0;
            valid_q      <= 1'b0;
            fs_q         <= 1'b0;
            le_q         <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            all_popped_q <= all_popped_d;
            pix_cnt_q    <= pix_cnt_d;
            valid_q      <= pop_s;
            fs_q         <= fs_d;
            le_q         <= le_d;
            done_q       <= (state_d == ST_DONE);
            ovf_q        <= ovf_d;
        end
    end

    assign valid_out       = valid_q;
    assign frame_start     = fs_q;
    assign line_end        = le_q;
    assign done            = done_q;
    assign pixel_count     = pix_cnt_q;
    assign csr.csr_level_r = level_s;
    assign csr.csr_full_r  = full_s;
    assign csr.overflow    = ovf_q;
endmodule
